// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared op, status, limit and FSM encodings for the mat_ops scheduler
package mat_pkg;

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_SCALE     = 3'b010;
  localparam logic [2:0] OP_MATMUL    = 3'b011;
  localparam logic [2:0] OP_CONV      = 3'b100;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DPERR   = 2'b01;
  localparam logic [1:0] ST_REJECT  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [2:0] MAT_DIM_MAX = 3'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a_m;
    logic [2:0] a_n;
    logic [2:0] b_m;
    logic [2:0] b_n;
    logic [7:0] k;
  } mat_cmd_t;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= MAT_DIM_MAX);
  endfunction

  // B dims only matter for the two-operand ops (add, matmul).
  function automatic logic cmd_reject(input mat_cmd_t c);
    logic bad;
    bad = !dim_ok(c.a_m) || !dim_ok(c.a_n) || (c.op > OP_MATMUL);
    if (c.op == OP_ADD)
      bad = bad || !dim_ok(c.b_m) || !dim_ok(c.b_n) || (c.a_m != c.b_m) || (c.a_n != c.b_n);
    if (c.op == OP_MATMUL)
      bad = bad || !dim_ok(c.b_m) || !dim_ok(c.b_n) || (c.a_n != c.b_m);
    return bad;
  endfunction

endpackage

// File: rtl/mat_rr_arb.sv
// rtl/mat_rr_arb.sv - combinational round-robin grant, lowest index strictly after last grant
module mat_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [$clog2(N_REQ)-1:0] i_last_grant,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_gnt_idx,
  output logic                     o_gnt_any
);
  localparam int IW = $clog2(N_REQ);

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!o_gnt_any && i_req_valid[(int'(i_last_grant) + i) % N_REQ]) begin
        o_gnt_any = 1'b1;
        o_gnt[(int'(i_last_grant) + i) % N_REQ] = 1'b1;
        o_gnt_idx = IW'((int'(i_last_grant) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/mat_ops_sched.sv
// rtl/mat_ops_sched.sv - request scheduler/sequencer in front of mat_ops
// Optional WAIT watchdog and timeout status: MAT_SCHED_WATCHDOG_EN.
module mat_ops_sched
  import mat_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [3*N_REQ-1:0]         req_op_flat,
  input  logic [12*N_REQ-1:0]        req_dim_flat,
  input  logic [8*N_REQ-1:0]         req_scalar_flat,
  output logic                       ops_start,
  output logic [2:0]                 ops_op_sel,
  output logic [2:0]                 ops_dim_a_m,
  output logic [2:0]                 ops_dim_a_n,
  output logic [2:0]                 ops_dim_b_m,
  output logic [2:0]                 ops_dim_b_n,
  output logic [7:0]                 ops_scalar_k,
  output logic [$clog2(N_REQ)-1:0]   ops_src_sel,
  input  logic                       ops_busy,
  input  logic                       ops_done,
  input  logic                       ops_error,
  input  logic [2:0]                 ops_res_m,
  input  logic [2:0]                 ops_res_n,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [1:0]                 rsp_status,
  output logic [2:0]                 rsp_m,
  output logic [2:0]                 rsp_n,
  output logic                       sched_busy
);
  localparam int IW = $clog2(N_REQ);

  logic [2:0]    r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_src;
  mat_cmd_t      r_cmd;
  logic [1:0]    r_status;
  logic [2:0]    r_res_m;
  logic [2:0]    r_res_n;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_gnt_any;
  logic             w_accept;
  logic             w_wd_expire;
  mat_cmd_t         w_req_cmd;

  mat_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last),
    .o_gnt        (w_gnt),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_any    (w_gnt_any)
  );

  // A busy or errored datapath holds off acceptance, which also covers reset mid-operation.
  assign w_accept  = (r_state == S_IDLE) && !ops_busy && !ops_error && w_gnt_any;
  assign w_req_cmd = {req_op_flat[3*int'(w_gnt_idx) +: 3],
                      req_dim_flat[12*int'(w_gnt_idx) +: 12],
                      req_scalar_flat[8*int'(w_gnt_idx) +: 8]};

`ifdef MAT_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC);
  logic [WW-1:0] r_wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state == S_ISSUE)
      r_wd_cnt <= '0;
    else if (r_state == S_WAIT && r_wd_cnt != '1)
      r_wd_cnt <= r_wd_cnt + WW'(1);
  end

  assign w_wd_expire = (r_state == S_WAIT) && (r_wd_cnt == WW'(TIMEOUT_CYC - 1));
`else
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(N_REQ - 1);
      r_src    <= '0;
      r_cmd    <= '0;
      r_status <= ST_OK;
      r_res_m  <= '0;
      r_res_n  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cmd   <= w_req_cmd;
          r_src   <= w_gnt_idx;
          r_last  <= w_gnt_idx;
          r_res_m <= '0;
          r_res_n <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: if (cmd_reject(r_cmd)) begin
          r_status <= ST_REJECT;
          r_state  <= S_RESP;
        end else begin
          r_state  <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (ops_done) begin
          r_res_m  <= ops_res_m;
          r_res_n  <= ops_res_n;
          r_status <= ST_OK;
          r_state  <= S_RESP;
        end else if (ops_error) begin
          r_status <= ST_DPERR;
          r_state  <= S_CLEAR;
        end else if (w_wd_expire) begin
          r_status <= ST_TIMEOUT;
          r_state  <= S_RESP;
        end
        S_CLEAR: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = w_accept ? w_gnt : '0;
  assign ops_start    = (r_state == S_ISSUE) || (r_state == S_CLEAR);
  assign ops_op_sel   = r_cmd.op;
  assign ops_dim_a_m  = r_cmd.a_m;
  assign ops_dim_a_n  = r_cmd.a_n;
  assign ops_dim_b_m  = r_cmd.b_m;
  assign ops_dim_b_n  = r_cmd.b_n;
  assign ops_scalar_k = r_cmd.k;
  assign ops_src_sel  = r_src;
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_id       = r_src;
  assign rsp_status   = r_status;
  assign rsp_m        = r_res_m;
  assign rsp_n        = r_res_n;
  assign sched_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mat_ops_sched.sv
// tb/tb_mat_ops_sched.sv - self-checking bench for mat_ops_sched with a datapath stand-in
module tb_mat_ops_sched;
  localparam int N_REQ = 2;
`ifdef MAT_SCHED_WATCHDOG_EN
  localparam int TIMEOUT_CYC = 16;
`else
  localparam int TIMEOUT_CYC = 512;
`endif
  localparam int IW = $clog2(N_REQ);

  logic clk = 1'b0;
  logic rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [3*N_REQ-1:0]  req_op_flat;
  logic [12*N_REQ-1:0] req_dim_flat;
  logic [8*N_REQ-1:0]  req_scalar_flat;
  logic                ops_start;
  logic [2:0]          ops_op_sel, ops_dim_a_m, ops_dim_a_n, ops_dim_b_m, ops_dim_b_n;
  logic [7:0]          ops_scalar_k;
  logic [IW-1:0]       ops_src_sel;
  logic                ops_busy, ops_done, ops_error;
  logic [2:0]          ops_res_m, ops_res_n;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [1:0]          rsp_status;
  logic [2:0]          rsp_m, rsp_n;
  logic                sched_busy;

  int want_cnt [N_REQ];
  int acc_cnt [N_REQ];
  int n_cmp, n_bad;
  int rsp_seen;
  int dp_mode, dp_lat;
  logic dp_release;
  int grant_log[$];
  logic [1:0]  last_status;
  logic [2:0]  last_m, last_n;
  logic [IW-1:0] last_id;
  logic [11:0] last_start_dims;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < N_REQ; i++) req_valid[i] = (want_cnt[i] != acc_cnt[i]);
  end

  mat_ops_sched #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_flat(req_op_flat), .req_dim_flat(req_dim_flat), .req_scalar_flat(req_scalar_flat),
    .ops_start(ops_start), .ops_op_sel(ops_op_sel),
    .ops_dim_a_m(ops_dim_a_m), .ops_dim_a_n(ops_dim_a_n),
    .ops_dim_b_m(ops_dim_b_m), .ops_dim_b_n(ops_dim_b_n),
    .ops_scalar_k(ops_scalar_k), .ops_src_sel(ops_src_sel),
    .ops_busy(ops_busy), .ops_done(ops_done), .ops_error(ops_error),
    .ops_res_m(ops_res_m), .ops_res_n(ops_res_n),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_status(rsp_status),
    .rsp_m(rsp_m), .rsp_n(rsp_n), .sched_busy(sched_busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit dim_in(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd5);
  endfunction

  function automatic bit legal(input logic [2:0] op, input logic [2:0] am, input logic [2:0] an,
                               input logic [2:0] bm, input logic [2:0] bn);
    case (op)
      3'd0, 3'd2: return dim_in(am) && dim_in(an);
      3'd1:       return dim_in(am) && dim_in(an) && dim_in(bm) && dim_in(bn) && am == bm && an == bn;
      3'd3:       return dim_in(am) && dim_in(an) && dim_in(bm) && dim_in(bn) && an == bm;
      default:    return 1'b0;
    endcase
  endfunction

  // Datapath stand-in: 0 = done after dp_lat cycles, 1 = sticky error, 2 = busy until released.
  initial begin : dp
    logic start_prev;
    int   cnt;
    start_prev = 1'b0; cnt = 0;
    ops_busy = 1'b0; ops_done = 1'b0; ops_error = 1'b0; ops_res_m = '0; ops_res_n = '0;
    forever begin
      @(posedge clk); #1;
      ops_done = 1'b0;
      if (rst) begin
        ops_busy = 1'b0; ops_error = 1'b0; cnt = 0; start_prev = 1'b0;
      end else begin
        if (start_prev) begin
          if (ops_error) ops_error = 1'b0;
          else begin ops_busy = 1'b1; cnt = dp_lat; end
        end else if (ops_busy && dp_mode == 2) begin
          if (dp_release) ops_busy = 1'b0;
        end else if (ops_busy) begin
          cnt--;
          if (cnt <= 0) begin
            ops_busy = 1'b0;
            if (dp_mode == 1) ops_error = 1'b1;
            else begin
              ops_done = 1'b1;
              case (ops_op_sel)
                3'd0:    begin ops_res_m = ops_dim_a_n; ops_res_n = ops_dim_a_m; end
                3'd3:    begin ops_res_m = ops_dim_a_m; ops_res_n = ops_dim_b_n; end
                default: begin ops_res_m = ops_dim_a_m; ops_res_n = ops_dim_a_n; end
              endcase
            end
          end
        end
        start_prev = ops_start;
      end
    end
  end

  // Scoreboard: one command in flight; checks grant order, field stability, starts and response timing.
  initial begin : mon
    int cyc, m_last, acc_cyc, start_cnt, first_start, done_cyc, err_cyc, g, exp_g, drop, e_starts;
    logic pending;
    logic [22:0] c_cmd;
    logic [2:0] c_op, c_am, c_an, c_bm, c_bn;
    logic [1:0] e_status;
    logic [2:0] e_m, e_n;
    logic [IW-1:0] e_id;
    cyc = 0; m_last = N_REQ - 1; pending = 1'b0; rsp_seen = 0;
    acc_cyc = 0; start_cnt = 0; first_start = 0; done_cyc = -1; err_cyc = -1;
    e_status = '0; e_m = '0; e_n = '0; e_id = '0; c_cmd = '0;
    for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      drop = -1;
      if (rst) begin
        pending = 1'b0;
        m_last  = N_REQ - 1;
      end else begin
        chk("sched_busy", sched_busy, pending);
        if (!pending) begin
          chk("start_when_idle", ops_start, 0);
          chk("rsp_when_idle", rsp_valid, 0);
        end else if (cyc > acc_cyc) begin
          chk("fields_stable", {ops_op_sel, ops_dim_a_m, ops_dim_a_n, ops_dim_b_m, ops_dim_b_n, ops_scalar_k}, c_cmd);
          chk("src_sel", ops_src_sel, e_id);
        end
        if (pending && ops_start) begin
          start_cnt++;
          if (start_cnt == 1) begin
            first_start = cyc;
            last_start_dims = {ops_dim_a_m, ops_dim_a_n, ops_dim_b_m, ops_dim_b_n};
            chk("start_latency", cyc - acc_cyc, 2);
          end else begin
            chk("clear_latency", cyc - err_cyc, 1);
          end
        end
        if (pending && ops_done) done_cyc = cyc;
        if (pending && ops_error && err_cyc < 0) err_cyc = cyc;
        if (pending && rsp_valid) begin
          rsp_seen++;
          chk("rsp_id", rsp_id, e_id);
          chk("rsp_status", rsp_status, e_status);
          chk("rsp_m", rsp_m, e_m);
          chk("rsp_n", rsp_n, e_n);
          e_starts = (e_status == 2'b10) ? 0 : (e_status == 2'b01) ? 2 : 1;
          chk("start_count", start_cnt, e_starts);
          case (e_status)
            2'b00:   chk("ok_rsp_latency", cyc - done_cyc, 1);
            2'b01:   chk("err_rsp_latency", cyc - err_cyc, 2);
            2'b10:   chk("rej_rsp_latency", cyc - acc_cyc, 2);
            default: chk("tmo_rsp_latency", cyc - first_start, TIMEOUT_CYC + 1);
          endcase
          last_status = rsp_status; last_m = rsp_m; last_n = rsp_n; last_id = rsp_id;
          pending = 1'b0;
        end
        if (req_ready != '0) begin
          chk("ready_onehot", $countones(req_ready), 1);
          chk("accept_gate", {ops_busy, ops_error, pending}, 0);
          exp_g = -1;
          for (int j = 1; j <= N_REQ; j++)
            if (exp_g < 0 && req_valid[(m_last + j) % N_REQ]) exp_g = (m_last + j) % N_REQ;
          g = 0;
          for (int i = N_REQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
          chk("grant_index", g, exp_g);
          m_last = g;
          grant_log.push_back(g);
          c_cmd = {req_op_flat[3*g +: 3], req_dim_flat[12*g +: 12], req_scalar_flat[8*g +: 8]};
          {c_op, c_am, c_an, c_bm, c_bn} = c_cmd[22:8];
          e_id = IW'(g);
          e_m = '0; e_n = '0;
          if (!legal(c_op, c_am, c_an, c_bm, c_bn)) e_status = 2'b10;
          else if (dp_mode == 1) e_status = 2'b01;
          else if (dp_mode == 2) e_status = 2'b11;
          else begin
            e_status = 2'b00;
            case (c_op)
              3'd0:    begin e_m = c_an; e_n = c_am; end
              3'd3:    begin e_m = c_am; e_n = c_bn; end
              default: begin e_m = c_am; e_n = c_an; end
            endcase
          end
          pending = 1'b1; acc_cyc = cyc; start_cnt = 0; done_cyc = -1; err_cyc = -1;
          drop = g;
        end
      end
      @(posedge clk); #1;
      if (drop >= 0) acc_cnt[drop]++;
    end
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] am, input logic [2:0] an,
                         input logic [2:0] bm, input logic [2:0] bn, input logic [7:0] k);
    req_op_flat[3*i +: 3]     = op;
    req_dim_flat[12*i +: 12]  = {am, an, bm, bn};
    req_scalar_flat[8*i +: 8] = k;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int t;
    t = 0;
    while (rsp_seen < target && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rsp_arrived", rsp_seen >= target, 1);
  endtask

  task automatic run_one(input int i, input logic [2:0] op, input logic [2:0] am, input logic [2:0] an,
                         input logic [2:0] bm, input logic [2:0] bn, input logic [7:0] k);
    int target;
    target = rsp_seen + 1;
    set_req(i, op, am, an, bm, bn, k);
    want_cnt[i]++;
    wait_rsp(target, 100);
  endtask

  initial begin : stim
    int target, acc_before, t;
    int exp_grants [4];
    exp_grants = '{0, 1, 0, 1};
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < N_REQ; i++) want_cnt[i] = 0;
    req_op_flat = '0; req_dim_flat = '0; req_scalar_flat = '0;
    dp_mode = 0; dp_lat = 3; dp_release = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_ops_start", ops_start, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_sched_busy", sched_busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_ops_fields", {ops_op_sel, ops_dim_a_m, ops_dim_a_n, ops_scalar_k, ops_src_sel}, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // both requesters valid from reset: strict alternation starting at 0
    set_req(0, 3'd0, 3'd2, 3'd3, 3'd0, 3'd0, 8'd0);
    set_req(1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd0, 8'hFD);
    target = rsp_seen + 4;
    want_cnt[0] += 2;
    want_cnt[1] += 2;
    wait_rsp(target, 200);
    chk("grant_log_len", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], exp_grants[i]);

    // matmul 2x3 * 3x2
    run_one(0, 3'd3, 3'd2, 3'd3, 3'd3, 3'd2, 8'd5);
    chk("mm_start_dims", last_start_dims, 12'h4DA);
    chk("mm_status", last_status, 0);
    chk("mm_rsp_m", last_m, 2);
    chk("mm_rsp_n", last_n, 2);
    chk("mm_rsp_id", last_id, 0);

    // rejects
    run_one(1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 8'd0);
    chk("add_mismatch_status", last_status, 2);
    run_one(0, 3'd4, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0);
    chk("op_j_status", last_status, 2);
    run_one(1, 3'd0, 3'd0, 3'd3, 3'd1, 3'd1, 8'd0);
    chk("dim0_status", last_status, 2);
    run_one(0, 3'd0, 3'd3, 3'd6, 3'd1, 3'd1, 8'd0);
    chk("dim6_status", last_status, 2);
    run_one(1, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 8'd0);
    chk("op7_status", last_status, 2);
    run_one(0, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 8'd0);
    chk("mm_inner_mismatch", last_status, 2);

    // legal boundaries
    run_one(1, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 8'd1);
    chk("add_5x5_status", last_status, 0);
    chk("add_5x5_m", last_m, 5);
    run_one(0, 3'd3, 3'd1, 3'd5, 3'd5, 3'd1, 8'd0);
    chk("mm_1x1_status", last_status, 0);
    chk("mm_1x1_n", last_n, 1);

    // datapath error then normal recovery
    dp_mode = 1;
    run_one(1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 8'd7);
    chk("dperr_status", last_status, 1);
    chk("dperr_rsp_m", last_m, 0);
    dp_mode = 0;
    run_one(0, 3'd0, 3'd4, 3'd1, 3'd0, 3'd0, 8'd0);
    chk("after_err_status", last_status, 0);
    chk("after_err_m", last_m, 1);
    chk("after_err_n", last_n, 4);

`ifdef MAT_SCHED_WATCHDOG_EN
    dp_mode = 2;
    run_one(1, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0, 8'd0);
    chk("timeout_status", last_status, 3);
    set_req(0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 8'd3);
    acc_before = acc_cnt[0];
    target = rsp_seen + 1;
    want_cnt[0]++;
    repeat (20) @(negedge clk);
    #1;
    chk("no_accept_while_busy", acc_cnt[0], acc_before);
    @(posedge clk); #2;
    dp_release = 1'b1;
    t = 0;
    while (ops_busy && t < 10) begin @(posedge clk); #2; t++; end
    chk("busy_released", ops_busy, 0);
    dp_mode = 0;
    dp_release = 1'b0;
    wait_rsp(target, 100);
    chk("post_timeout_status", last_status, 0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
